// File: rtl/axi4_read_test_impl.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_read_test_impl
//  Description : AXI4 read-side traffic checker. On a rising edge of start it
//                issues C_BURST_COUNT INCR bursts of 16 beats from
//                C_BASE_ADDR and compares every returned beat against a
//                counting pattern, flagging a sticky error on any mismatch.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_read_test_impl #(
    parameter int                            C_M_AXI_ID_WIDTH   = 1,
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = 32'h1000_0000,
    parameter int                            C_BURST_COUNT      = 16
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            start,
    output logic                            done,
    output logic                            error,
    // Write address channel (unused, tied off)
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWLOCK,
    output logic [3:0]                      M_AXI_AWCACHE,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic [3:0]                      M_AXI_AWQOS,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    // Write data channel (unused, tied off)
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    // Write response channel (always accepted, ignored)
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    // Read address channel
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    output logic                            M_AXI_ARLOCK,
    output logic [3:0]                      M_AXI_ARCACHE,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic [3:0]                      M_AXI_ARQOS,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    // Read data channel
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] c_BURST_BYTES =
        C_M_AXI_ADDR_WIDTH'(16 * C_M_AXI_DATA_WIDTH / 8);
    localparam logic [2:0] c_ARSIZE      = (C_M_AXI_DATA_WIDTH == 64) ? 3'd3 : 3'd2;
    localparam logic [8:0] c_BURST_TOTAL = 9'(C_BURST_COUNT);
    localparam int         c_PAT_REPS    = C_M_AXI_DATA_WIDTH / 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic                            r_start_d;
    logic                            r_error;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_araddr;
    logic [8:0]                      r_burst_cnt;   // bursts completed this run
    logic [15:0]                     r_beat_cnt;    // global beat index k

    logic                            w_start_rise;
    logic                            w_beat;
    logic                            w_last_beat;
    logic                            w_more_bursts;
    logic                            w_beat_is_15;
    logic [C_M_AXI_DATA_WIDTH-1:0]   w_exp_data;
    logic                            w_beat_err;
    logic                            w_unused;

    // Write-channel tie-offs; responses are always accepted and ignored.
    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = '0;
    assign M_AXI_AWLEN   = '0;
    assign M_AXI_AWSIZE  = '0;
    assign M_AXI_AWBURST = '0;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = '0;
    assign M_AXI_AWPROT  = '0;
    assign M_AXI_AWQOS   = '0;
    assign M_AXI_AWVALID = 1'b0;
    assign M_AXI_WDATA   = '0;
    assign M_AXI_WSTRB   = '0;
    assign M_AXI_WLAST   = 1'b0;
    assign M_AXI_WVALID  = 1'b0;
    assign M_AXI_BREADY  = 1'b1;
    assign w_unused      = &{1'b0, M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BID,
                             M_AXI_BRESP, M_AXI_BVALID};

    // Fixed read-burst attributes: 16-beat INCR, full-width beats.
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARLEN   = 8'd15;
    assign M_AXI_ARSIZE  = c_ARSIZE;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;
    assign M_AXI_ARADDR  = r_araddr;
    assign error         = r_error;

    assign w_start_rise  = start & ~r_start_d;
    assign w_beat        = (r_state == S_DATA) & M_AXI_RVALID;
    assign w_beat_is_15  = (r_beat_cnt[3:0] == 4'hF);
    assign w_last_beat   = w_beat & w_beat_is_15;
    assign w_more_bursts = (r_burst_cnt + 9'd1) < c_BURST_TOTAL;

    // Pattern {~k, k} for the current global beat, replicated across the bus.
    assign w_exp_data    = {c_PAT_REPS{~r_beat_cnt, r_beat_cnt}};

    // A beat is bad on data, response, ID, or RLAST in the wrong position.
    assign w_beat_err    = (M_AXI_RDATA != w_exp_data) |
                           (M_AXI_RRESP != 2'b00)      |
                           (M_AXI_RID   != '0)         |
                           (M_AXI_RLAST != w_beat_is_15);

    // State register.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt   = r_state;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_rise) begin
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                M_AXI_RREADY = 1'b1;
                // The 16th accepted beat ends the burst whatever RLAST says.
                if (w_last_beat) begin
                    w_state_nxt = w_more_bursts ? S_ADDR : S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (!start) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Start-edge detector; sampled every cycle so edges outside IDLE are lost.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_start_d <= 1'b0;
        end else begin
            r_start_d <= start;
        end
    end

    // Run bookkeeping: address, counters and sticky error flag.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_error     <= 1'b0;
            r_araddr    <= C_BASE_ADDR;
            r_burst_cnt <= '0;
            r_beat_cnt  <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_start_rise) begin
                r_error     <= 1'b0;
                r_araddr    <= C_BASE_ADDR;
                r_burst_cnt <= '0;
                r_beat_cnt  <= '0;
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 16'd1;
                if (w_beat_err) begin
                    r_error <= 1'b1;
                end
                if (w_beat_is_15) begin
                    r_burst_cnt <= r_burst_cnt + 9'd1;
                    if (w_more_bursts) begin
                        r_araddr <= r_araddr + c_BURST_BYTES;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_read_test_impl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_read_test_impl
//  Description : Directed bench for axi4_read_test_impl with a behavioural
//                AXI read slave returning the counting pattern, plus fault
//                injection (bad data, bad RRESP, early RLAST, mid-run reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_read_test_impl;

    localparam logic [31:0] c_BASE = 32'h1000_0000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        done;
    logic        error;
    logic [0:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic [3:0]  awqos;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
    logic [0:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [3:0]  arqos;
    logic        arvalid;
    logic        arready;
    logic [0:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int tests_run    = 0;
    int tests_failed = 0;

    // Slave configuration (-1 disables a fault) and per-run statistics.
    int cfg_ar_delay, cfg_gap, cfg_bad_k, cfg_resp_k, cfg_rlast_k, cfg_reset_k, cfg_toggle_k;
    int st_ar, st_k, st_viol, st_first_err;
    bit st_done, st_reset_hit;

    axi4_read_test_impl dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .start         (start),
        .done          (done),
        .error         (error),
        .M_AXI_AWID    (awid),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWLEN   (awlen),
        .M_AXI_AWSIZE  (awsize),
        .M_AXI_AWBURST (awburst),
        .M_AXI_AWLOCK  (awlock),
        .M_AXI_AWCACHE (awcache),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_AWQOS   (awqos),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (1'b0),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WLAST   (wlast),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (1'b0),
        .M_AXI_BID     (1'b0),
        .M_AXI_BRESP   (2'b00),
        .M_AXI_BVALID  (1'b0),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARID    (arid),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARLEN   (arlen),
        .M_AXI_ARSIZE  (arsize),
        .M_AXI_ARBURST (arburst),
        .M_AXI_ARLOCK  (arlock),
        .M_AXI_ARCACHE (arcache),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARQOS   (arqos),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RID     (rid),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RLAST   (rlast),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int k);
        logic [15:0] kk;
        kk = k[15:0];
        return {~kk, kk};
    endfunction

    task automatic cfg_clear();
        cfg_ar_delay = 0;  cfg_gap = 0;      cfg_bad_k = -1;   cfg_resp_k = -1;
        cfg_rlast_k  = -1; cfg_reset_k = -1; cfg_toggle_k = -1;
    endtask

    task automatic idle_slave();
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        rdata   = '0;   rresp  = 2'b00; rid  = '0;
    endtask

    // Behavioural slave. Each negedge: retire the handshake of the previous
    // posedge, check the master's outputs, then drive the next cycle.
    task automatic run_slave(input int budget);
        int  ph, arwait, bib, k;
        bit  skip, p_arvalid, p_rready;
        logic [31:0] p_araddr;
        ph = 0; arwait = 0; bib = 0; k = 0; skip = 0;
        p_arvalid = 0; p_rready = 0; p_araddr = '0;
        st_ar = 0; st_k = 0; st_viol = 0; st_first_err = -1;
        st_done = 0; st_reset_hit = 0;
        idle_slave();
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (ph == 0 && arready && p_arvalid) begin
                st_ar++; ph = 1; arready = 1'b0; arwait = 0; bib = 0;
            end else if (ph == 1 && rvalid && p_rready) begin
                k++; bib++; rvalid = 1'b0; rlast = 1'b0; skip = (cfg_gap != 0);
                if (bib == 16) ph = 0;
            end
            st_k = k;
            if (error && st_first_err < 0) st_first_err = k;
            if (done) begin st_done = 1; break; end
            if (cfg_reset_k >= 0 && k >= cfg_reset_k) begin st_reset_hit = 1; break; end
            if (ph == 1 && arvalid) st_viol++;
            if (ph == 0 && rready) st_viol++;
            if (ph == 0 && p_arvalid && !arvalid) st_viol++;
            if (ph == 0 && arvalid) begin
                if (araddr !== c_BASE + 32'(64 * st_ar)) st_viol++;
                if (p_arvalid && araddr !== p_araddr) st_viol++;
            end
            if (cfg_toggle_k >= 0 && k == cfg_toggle_k) start = 1'b0;
            if (cfg_toggle_k >= 0 && k == cfg_toggle_k + 1) start = 1'b1;
            if (ph == 0) begin
                if (arvalid) begin
                    if (arwait >= cfg_ar_delay) arready = 1'b1;
                    else arwait++;
                end
            end else if (!rvalid) begin
                if (skip) begin
                    skip = 0;
                end else begin
                    rvalid = 1'b1;
                    rdata  = (k == cfg_bad_k) ? 32'h0 : pat(k);
                    rresp  = (k == cfg_resp_k) ? 2'b10 : 2'b00;
                    rlast  = (bib == 15) || (k == cfg_rlast_k);
                    rid    = '0;
                end
            end
            p_arvalid = arvalid; p_rready = rready; p_araddr = araddr;
        end
        idle_slave();
    endtask

    task automatic launch_run();
        @(negedge clk);
        start = 1'b1;
        run_slave(5000);
    endtask

    task automatic test_reset();
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", done); end
        tests_run++;
        if (error !== 1'b0) begin tests_failed++; $display("FAIL reset_error got=%b exp=0", error); end
        tests_run++;
        if (arvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_arvalid got=%b exp=0", arvalid); end
        tests_run++;
        if (rready !== 1'b0) begin tests_failed++; $display("FAIL reset_rready got=%b exp=0", rready); end
        tests_run++;
        if (araddr !== c_BASE) begin tests_failed++; $display("FAIL reset_araddr got=%h exp=%h", araddr, c_BASE); end
        tests_run++;
        if ({arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos} !==
            {1'b0, 8'd15, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000}) begin
            tests_failed++;
            $display("FAIL ar_fields got=%h/%h/%h/%h/%h/%h/%h/%h exp=0/0f/2/1/0/3/0/0",
                     arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos);
        end
        tests_run++;
        if ({awvalid, wvalid, wlast, bready, awaddr, wdata, wstrb} !== {3'b000, 1'b1, 68'h0}) begin
            tests_failed++;
            $display("FAIL write_tieoff got aw=%b w=%b b=%b exp aw=0 w=0 b=1", awvalid, wvalid, bready);
        end
    endtask

    task automatic test_normal();
        cfg_clear();
        launch_run();
        tests_run++;
        if (!(st_done && st_ar == 16 && st_k == 256 && st_viol == 0)) begin
            tests_failed++;
            $display("FAIL normal_run got done=%0d ar=%0d beats=%0d viol=%0d exp 1/16/256/0", st_done, st_ar, st_k, st_viol);
        end
        tests_run++;
        if (error !== 1'b0) begin tests_failed++; $display("FAIL normal_error got=%b exp=0", error); end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1) begin tests_failed++; $display("FAIL normal_done_hold got=%b exp=1", done); end
        start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL normal_done_clear got=%b exp=0", done); end
    endtask

    task automatic test_bad_data();
        cfg_clear();
        cfg_bad_k = 37;
        launch_run();
        tests_run++;
        if (!(st_done && st_ar == 16 && st_k == 256)) begin
            tests_failed++;
            $display("FAIL bad_data_run got done=%0d ar=%0d beats=%0d exp 1/16/256", st_done, st_ar, st_k);
        end
        tests_run++;
        if (error !== 1'b1 || st_first_err != 38) begin
            tests_failed++;
            $display("FAIL bad_data_error got err=%b first_after=%0d exp err=1 first_after=38", error, st_first_err);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || error !== 1'b1) begin
            tests_failed++;
            $display("FAIL bad_data_retain got done=%b err=%b exp done=0 err=1", done, error);
        end
    endtask

    task automatic test_rresp();
        cfg_clear();
        cfg_resp_k = 3 * 16 + 5;
        launch_run();
        tests_run++;
        if (!(st_done && st_ar == 16 && st_k == 256 && st_viol == 0)) begin
            tests_failed++;
            $display("FAIL rresp_run got done=%0d ar=%0d beats=%0d viol=%0d exp 1/16/256/0", st_done, st_ar, st_k, st_viol);
        end
        tests_run++;
        if (error !== 1'b1 || st_first_err != 54) begin
            tests_failed++;
            $display("FAIL rresp_error got err=%b first_after=%0d exp err=1 first_after=54", error, st_first_err);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_slow_slave();
        cfg_clear();
        cfg_ar_delay = 5; cfg_gap = 1; cfg_toggle_k = 20;
        launch_run();
        tests_run++;
        if (!(st_done && st_ar == 16 && st_k == 256 && st_viol == 0)) begin
            tests_failed++;
            $display("FAIL slow_run got done=%0d ar=%0d beats=%0d viol=%0d exp 1/16/256/0", st_done, st_ar, st_k, st_viol);
        end
        tests_run++;
        if (error !== 1'b0) begin tests_failed++; $display("FAIL slow_error got=%b exp=0", error); end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_early_rlast();
        cfg_clear();
        cfg_rlast_k = 10;
        launch_run();
        tests_run++;
        if (!(st_done && st_ar == 16 && st_k == 256 && st_viol == 0)) begin
            tests_failed++;
            $display("FAIL rlast_run got done=%0d ar=%0d beats=%0d viol=%0d exp 1/16/256/0", st_done, st_ar, st_k, st_viol);
        end
        tests_run++;
        if (error !== 1'b1 || st_first_err != 11) begin
            tests_failed++;
            $display("FAIL rlast_error got err=%b first_after=%0d exp err=1 first_after=11", error, st_first_err);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        cfg_clear();
        cfg_bad_k = 35; cfg_reset_k = 40;
        launch_run();
        tests_run++;
        if (!(st_reset_hit && error === 1'b1 && rready === 1'b1)) begin
            tests_failed++;
            $display("FAIL midrun_setup got hit=%0d err=%b rready=%b exp 1/1/1", st_reset_hit, error, rready);
        end
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        tests_run++;
        if ({done, error, arvalid, rready} !== 4'b0000 || araddr !== c_BASE) begin
            tests_failed++;
            $display("FAIL midrun_async_reset got done=%b err=%b arv=%b rr=%b addr=%h exp 0/0/0/0/%h",
                     done, error, arvalid, rready, araddr, c_BASE);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || arvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_quiet got done=%b arv=%b exp 0/0", done, arvalid);
        end
        cfg_clear();
        launch_run();
        tests_run++;
        if (!(st_done && st_ar == 16 && st_k == 256 && st_viol == 0) || error !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_fresh_run got done=%0d ar=%0d beats=%0d viol=%0d err=%b exp 1/16/256/0/0",
                     st_done, st_ar, st_k, st_viol, error);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        cfg_clear();
        idle_slave();
        start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_normal();
        test_bad_data();
        test_rresp();
        test_slow_slave();
        test_early_rlast();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi4_read_test_impl.md
AXI4_READ_TEST_IMPL -- requirements
Module: axi4_read_test_impl

Interface
REQ-001 Parameter C_M_AXI_ID_WIDTH, default 1: width of ARID/RID.
REQ-002 Parameter C_M_AXI_ADDR_WIDTH, default 32: width of ARADDR.
REQ-003 Parameter C_M_AXI_DATA_WIDTH, default 32: width of RDATA; SHALL be 32 or 64.
REQ-004 Parameter C_BASE_ADDR, default 32'h1000_0000: first burst address, aligned to 16*DATA_WIDTH/8.
REQ-005 Parameter C_BURST_COUNT, default 16: number of 16-beat bursts per run, 1..256.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-low. Ports are M_AXI_ACLK (input, 1, clock) and M_AXI_ARESETN (input, 1, async active-low reset).
REQ-007 start  input  1  run request, edge-detected (rising).
REQ-008 done  output  1  run complete.
REQ-009 error  output  1  sticky mismatch/protocol error for current or last run.
REQ-010 M_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARQOS  output  ID/ADDR/8/3/2/1/4/3/4  read address channel.
REQ-011 M_AXI_ARVALID output 1, M_AXI_ARREADY input 1: read address handshake.
REQ-012 M_AXI_RID/RDATA/RRESP/RLAST/RVALID  input  ID/DATA/2/1/1  read data channel.
REQ-013 M_AXI_RREADY  output  1  read data accept.
REQ-014 All write-channel ports (AW*, W*, B*) present as on the write test block; outputs SHALL be constant 0 except BREADY=1.

Function
REQ-015 Constant AR fields: ARID=0, ARLEN=15, ARSIZE=log2(DATA_WIDTH/8), ARBURST=INCR(01), ARLOCK=0, ARCACHE=4'b0011, ARPROT=0, ARQOS=0.
REQ-016 FSM states IDLE, ADDR, DATA, DONE; one burst outstanding at most.
REQ-017 IDLE: rising edge of start (start=1 this cycle, 0 previous) -> ADDR next cycle; clears error, burst counter, beat counter; ARADDR=C_BASE_ADDR.
REQ-018 ADDR: ARVALID=1; ARADDR and AR fields stable until ARREADY sampled high; then -> DATA, ARVALID=0 next cycle.
REQ-019 DATA: RREADY=1; each RVALID&RREADY beat compared and beat counter incremented.
REQ-020 Expected RDATA for global beat index k (0..16*C_BURST_COUNT-1) = {~k[15:0], k[15:0]} replicated to DATA_WIDTH.
REQ-021 error set (sticky) on any accepted beat with: RDATA != expected, RRESP != 00, RID != 0, RLAST=1 on beat 0..14 of burst, or RLAST=0 on beat 15.
REQ-022 Burst ends on 16th accepted beat regardless of RLAST; early RLAST flags error but does not end burst.
REQ-023 After burst end: if bursts done < C_BURST_COUNT -> ADDR with ARADDR += 16*DATA_WIDTH/8; else -> DONE.
REQ-024 DONE: done=1; held while start=1; start=0 -> IDLE, done=0; error retained until next start edge.
REQ-025 start edges while not IDLE ignored.
REQ-026 RREADY=0 outside DATA; ARVALID=0 outside ADDR.
REQ-027 Beat counter width >= 12 bits; no wrap within a run.

Reset
REQ-028 M_AXI_ARESETN=0 asynchronously forces IDLE; done=0, error=0, ARVALID=0, RREADY=0, ARADDR=C_BASE_ADDR, counters=0, start-edge register=0.
REQ-029 Reset mid-run abandons run; no completion; next start edge after release begins fresh run.

Verification
REQ-030 Defaults, zero-wait slave returning pattern -> 16 AR handshakes at 0x1000_0000, +0x40 each; 256 beats; done=1, error=0.
REQ-031 Beat k=37 returns 0 -> error=1 after that beat; all 16 bursts still completed; done=1.
REQ-032 RRESP=10 on burst 3 beat 5, data correct -> error=1, done=1.
REQ-033 ARREADY delayed 5 cycles, RVALID gaps every other cycle -> ARADDR/ARVALID stable while waiting; error=0, done=1.
REQ-034 RLAST on beat 10 of burst 0 -> error=1; burst still ends after beat 15.
REQ-035 ARESETN low during burst 2 DATA -> all outputs reset immediately; new start edge -> clean run, done=1, error=0.
